// File: rtl/mac_operand_feeder.sv
// Operand feeder: queues (a,b) pairs and streams one vector of them into a MAC.
// Latency: acc_clr one cycle after start accept; issue registered one cycle after pop; done one cycle after the DONE state.
// Backpressure: in_ready = !full; RUN stalls (zero operands, mac_en=0) while the FIFO is empty.
module mac_operand_feeder #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             abort,
  output logic [7:0]       a_out,
  output logic [7:0]       b_out,
  output logic             mac_en,
  output logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Operand-pair storage; {a,b} packed per entry.
  logic [15:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             r_full;
  logic             r_empty;

  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic             r_mac_en;
  logic             r_acc_clr;
  logic             r_done;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_accept;
  logic [AW-1:0]    w_wr_ptr_inc;
  logic [AW-1:0]    w_rd_ptr_inc;
  logic [15:0]      w_head;

  // A push or pop on an aborting edge is dropped: the abort flushes the queue.
  assign w_push       = in_valid && !r_full && !abort;
  assign w_pop        = (r_state == S_RUN) && !r_empty && !abort;
  assign w_accept     = (r_state == S_IDLE) && start && !abort;
  assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
  assign w_head       = r_mem[r_rd_ptr];

  assign in_ready = !r_full;
  assign busy     = (r_state != S_IDLE);
  assign a_out    = r_a;
  assign b_out    = r_b;
  assign mac_en   = r_mac_en;
  assign acc_clr  = r_acc_clr;
  assign done     = r_done;
  assign count    = r_count;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (vec_len != '0) ? S_CLEAR : S_DONE;
      S_CLEAR: w_state_nxt = S_RUN;
      S_RUN:   if (w_pop && (r_remaining == LEN_W'(1))) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  // FIFO storage write; contents need no reset since the flags gate reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_a, in_b};
  end

  // FIFO pointers and flags; simultaneous push and pop leave the flags as they are.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else if (abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          r_wr_ptr <= w_wr_ptr_inc;
          r_empty  <= 1'b0;
          r_full   <= (w_wr_ptr_inc == r_rd_ptr);
        end
        2'b01: begin
          r_rd_ptr <= w_rd_ptr_inc;
          r_full   <= 1'b0;
          r_empty  <= (w_rd_ptr_inc == r_wr_ptr);
        end
        2'b11: begin
          r_wr_ptr <= w_wr_ptr_inc;
          r_rd_ptr <= w_rd_ptr_inc;
        end
        default: ;
      endcase
    end
  end

  // Registered MAC-facing outputs, vector length tracking and issue count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_mac_en    <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
      r_count     <= '0;
    end else begin
      r_mac_en  <= w_pop;
      r_a       <= w_pop ? w_head[15:8] : 8'd0;
      r_b       <= w_pop ? w_head[7:0]  : 8'd0;
      r_acc_clr <= (w_state_nxt == S_CLEAR);
      r_done    <= (r_state == S_DONE) && !abort;
      if (w_accept) begin
        r_remaining <= vec_len;
        r_count     <= '0;
      end else if (w_pop) begin
        r_remaining <= r_remaining - 1'b1;
        r_count     <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Randomized and directed stimulus against a queue-based reference model of the feeder.
// Expected events (clear, issue, done) are queued at stimulus time and popped by a negedge monitor.
module tb_mac_operand_feeder;
  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] vec_len = '0;
  logic             abort = 1'b0;
  logic [7:0]       a_out;
  logic [7:0]       b_out;
  logic             mac_en;
  logic             acc_clr;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] count;

  mac_operand_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .start(start), .vec_len(vec_len), .abort(abort),
    .a_out(a_out), .b_out(b_out), .mac_en(mac_en), .acc_clr(acc_clr),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_CLR = 0, EV_ISSUE = 1, EV_DONE = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       a;
    int       b;
    int       cnt;
  } ev_t;

  ev_t  exp_q[$];
  int   mq_a[$];
  int   mq_b[$];
  int   need = 0;
  int   vec_n = 0;
  int   errors = 0;
  int   checks = 0;
  int   prod_sum = 0;
  logic last_mac_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Reference model: a vector of n consumes the next n queued pairs in order.
  task automatic model_drain();
    while (need > 0 && mq_a.size() > 0) begin
      push_ev(EV_ISSUE, mq_a.pop_front(), mq_b.pop_front(), 0);
      need--;
      if (need == 0) push_ev(EV_DONE, 0, 0, vec_n);
    end
  endtask

  task automatic model_start(input int n);
    vec_n = n;
    if (n == 0) push_ev(EV_DONE, 0, 0, 0);
    else begin
      push_ev(EV_CLR, 0, 0, 0);
      need = n;
      model_drain();
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    mq_a.delete();
    mq_b.delete();
    need = 0;
  endtask

  task automatic take(input ev_kind_t k, input int a, input int b, input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d, expected none", int'(k));
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    if (k == e.kind && k == EV_ISSUE) begin
      chk("issue_a", a, e.a);
      chk("issue_b", b, e.b);
    end
    if (k == e.kind && k == EV_DONE) begin
      chk("done_count", c, e.cnt);
      chk("done_after_last_issue", int'(last_mac_en), int'(e.cnt > 0));
    end
  endtask

  // Monitor: compares every output event with the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) last_mac_en = 1'b0;
    else begin
      if (acc_clr) take(EV_CLR, 0, 0, 0);
      if (mac_en) begin
        take(EV_ISSUE, int'(a_out), int'(b_out), 0);
        prod_sum += int'(a_out) * int'(b_out);
      end else begin
        chk("idle_operands_zero", int'({a_out, b_out}), 0);
      end
      if (done) begin
        take(EV_DONE, 0, 0, int'(count));
        chk("done_not_busy", int'(busy), 0);
      end
      last_mac_en = mac_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input int a, input int b);
    logic ok;
    int   n;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = 8'(a);
    in_b = 8'(b);
    while (!ok) begin
      ok = in_ready;
      tick();
      n++;
      if (!ok && n > 200) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: got in_ready 0, expected 1 within 200 cycles");
        break;
      end
    end
    in_valid = 1'b0;
    if (ok) begin
      mq_a.push_back(a);
      mq_b.push_back(b);
      model_drain();
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    vec_len = LEN_W'(n);
    tick();
    start = 1'b0;
    model_start(n);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy 1, expected 0 within 300 cycles");
    end
  endtask

  task automatic wait_mac_en();
    int n;
    n = 0;
    while (!mac_en && n < 20) begin
      tick();
      n++;
    end
    chk("mac_en_seen", int'(mac_en), 1);
  endtask

  initial begin
    int occ, k, n, left, need_push, e;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mac_en", int'(mac_en), 0);
    chk("rst_acc_clr", int'(acc_clr), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_operands", int'({a_out, b_out}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Three queued pairs, vector of three.
    prod_sum = 0;
    push_pair(3, 4);
    push_pair(5, 6);
    push_pair(7, 8);
    do_start(3);
    chk("clr_pulse", int'(acc_clr), 1);
    tick();
    chk("clr_one_cycle", int'(acc_clr), 0);
    wait_mac_en();
    for (int i = 0; i < 3; i++) begin
      chk("burst_mac_en", int'(mac_en), 1);
      tick();
    end
    chk("done_after_burst", int'(done), 1);
    chk("burst_count", int'(count), 3);
    chk("product_sum", prod_sum, 98);
    wait_idle();

    // Vector started on an empty FIFO; pairs trickle in.
    do_start(2);
    push_pair(2, 2);
    repeat (3) tick();
    push_pair(9, 9);
    wait_idle();
    tick();
    chk("count_holds", int'(count), 2);

    // Fill the FIFO, fifth pair held off until the vector drains it.
    for (int i = 0; i < 4; i++) push_pair(10 + i, 20 + i);
    chk("full_in_ready", int'(in_ready), 0);
    fork
      push_pair(50, 60);
      begin
        for (int i = 0; i < 2; i++) begin
          chk("held_off", int'(in_ready), 0);
          tick();
        end
        do_start(4);
      end
    join
    wait_idle();
    tick();

    // Zero-length vector leaves the queued pair alone.
    do_start(0);
    chk("zero_no_clr", int'(acc_clr), 0);
    chk("zero_busy", int'(busy), 1);
    tick();
    chk("zero_done", int'(done), 1);
    chk("zero_count", int'(count), 0);
    tick();

    // Abort coinciding with start in IDLE: start is dropped, FIFO flushed.
    start = 1'b1;
    vec_len = 8'd2;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    model_flush();
    chk("abort_beats_start", int'(busy), 0);

    // Abort after the first of three issues.
    push_pair(31, 32);
    push_pair(33, 34);
    push_pair(35, 36);
    do_start(3);
    wait_mac_en();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_flush();
    chk("abort_idle", int'(busy), 0);
    chk("abort_mac_en", int'(mac_en), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_operands", int'({a_out, b_out}), 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", int'(done), 0);
      tick();
    end
    push_pair(11, 12);
    do_start(1);
    wait_idle();
    tick();

    // Reset mid-RUN with pairs still queued.
    push_pair(41, 42);
    push_pair(43, 44);
    push_pair(45, 46);
    do_start(5);
    wait_mac_en();
    #2 rst_n = 1'b0;
    #1;
    model_flush();
    chk("midrst_mac_en", int'(mac_en), 0);
    chk("midrst_operands", int'({a_out, b_out}), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_done", int'(done), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Randomized vectors with leftover pairs carried between them.
    for (int v = 0; v < 25; v++) begin
      wait_idle();
      occ = mq_a.size();
      k = int'($urandom_range(0, DEPTH - occ));
      for (int i = 0; i < k; i++) push_pair(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      n = int'($urandom_range(0, 6));
      do_start(n);
      left = (occ + k > n) ? (occ + k - n) : 0;
      need_push = (n > occ + k) ? (n - occ - k) : 0;
      e = int'($urandom_range(0, DEPTH - left));
      for (int i = 0; i < need_push + e; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        push_pair(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      wait_idle();
      tick();
    end

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
